// File: rtl/sdram_wb_arbiter_if.sv
// sdram_wb_arbiter_if: bundle of the three master ports and the SDRAM controller port
interface sdram_wb_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic [2:0] m_cyc, m_stb, m_we, m_ack;
  logic [3*AW-1:0] m_adr;
  logic [11:0] m_sel;
  logic [8:0] m_cti;
  logic [3*DW-1:0] m_dat_i;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [3:0] s_sel;
  logic [2:0] s_cti;
  modport slave (
    input m_cyc, m_stb, m_we, m_adr, m_sel, m_cti, m_dat_i, s_dat_i, s_ack,
    output m_dat_o, m_ack, s_cyc, s_stb, s_we, s_adr, s_sel, s_cti, s_dat_o
  );
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_cti, m_dat_i, s_dat_i, s_ack,
    input m_dat_o, m_ack, s_cyc, s_stb, s_we, s_adr, s_sel, s_cti, s_dat_o
  );
endinterface

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: shares the SDRAM Wishbone port between video DMA, sound DMA and CPU
module sdram_wb_arbiter #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic sd_clk,
  input  logic reset,
  sdram_wb_arbiter_if.slave bus,
  output logic [2:0] grant,
  output logic busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, GAP = 2'd2;
  logic [1:0] state, g;
  logic rr, act, idle, s1, s2, pick2;
  logic [2:0] req, win;
  logic [CW-1:0] cnt1, cnt2;
  // request decode, owner index and winner selection (rr=0 prefers M1)
  always_comb begin
    req = bus.m_cyc & bus.m_stb;
    idle = state == IDLE;
    act = state == ACTIVE;
    g = grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
    s1 = req[1] && cnt1 >= LIM;
    s2 = req[2] && cnt2 >= LIM;
    pick2 = (s1 || s2) ? ((s1 && s2) ? rr : s2) : ((req[1] && req[2]) ? rr : req[2]);
    win = ~|req ? 3'b000 : (!(s1 || s2) && req[0]) ? 3'b001 : pick2 ? 3'b100 : 3'b010;
  end
  // controller port mirrors the owner while ACTIVE; acks return only to the owner
  always_comb begin
    bus.s_cyc = act & bus.m_cyc[g];
    bus.s_stb = act & bus.m_stb[g];
    bus.s_we = act & bus.m_we[g];
    bus.s_adr = bus.m_adr[int'(g)*AW +: AW];
    bus.s_sel = bus.m_sel[int'(g)*4 +: 4];
    bus.s_cti = bus.m_cti[int'(g)*3 +: 3];
    bus.s_dat_o = bus.m_dat_i[int'(g)*DW +: DW];
    bus.m_ack = (act && bus.s_ack) ? grant : 3'b000;
    bus.m_dat_o = bus.s_dat_i;
    busy = !idle;
  end
  // ownership state, round-robin pointer and M1/M2 starvation counters
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 3'b000;
      rr <= 1'b0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      state <= idle ? (|req ? ACTIVE : IDLE) : act ? (bus.m_cyc[g] ? ACTIVE : GAP) : IDLE;
      grant <= idle ? win : (act && bus.m_cyc[g]) ? grant : 3'b000;
      rr <= (idle && |win[2:1]) ? ~rr : rr;
      cnt1 <= (!req[1] || (idle && win[1]) || grant[1]) ? '0 : (cnt1 == LIM) ? cnt1 : cnt1 + 1'b1;
      cnt2 <= (!req[2] || (idle && win[2]) || grant[2]) ? '0 : (cnt2 == LIM) ? cnt2 : cnt2 + 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// tb_sdram_wb_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_sdram_wb_arbiter;
  localparam int AW = 24, DW = 32, LIM = 64;
  logic sd_clk = 1'b0;
  logic reset;
  logic [2:0] grant;
  logic busy;
  sdram_wb_arbiter_if #(.AW(AW), .DW(DW)) bus();
  sdram_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .sd_clk(sd_clk), .reset(reset), .bus(bus), .grant(grant), .busy(busy)
  );
  always #5 sd_clk = ~sd_clk;

  int n_vec = 0, n_bad = 0;
  // reference model: current owner (-1 none), gap flag, preferred of M1/M2, waiting ages
  int owner = -1;
  bit gap = 1'b0;
  int pref = 1;
  int age[3] = '{0, 0, 0};
  logic [2:0] exp_ack = 3'b000;

  typedef struct packed {
    logic rst;
    logic [2:0] rq;
    logic ack;
    logic [2:0] g;
    logic [2:0] mack;
    logic scyc;
    logic bsy;
  } vec_t;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [2:0] r);
    bit st1, st2;
    st1 = r[1] && age[1] >= LIM;
    st2 = r[2] && age[2] >= LIM;
    if (st1 && st2) return pref;
    if (st1) return 1;
    if (st2) return 2;
    if (r[0]) return 0;
    if (r[1] && r[2]) return pref;
    return r[1] ? 1 : 2;
  endfunction

  // compare every output with the model, clock once, advance the model
  task automatic step();
    logic [2:0] r, eg, ea;
    logic ec, es, ew, eb;
    bit rs, ngap;
    int nown;
    r = bus.m_cyc & bus.m_stb;
    rs = reset;
    eg = 3'b000; ea = 3'b000; ec = 1'b0; es = 1'b0; ew = 1'b0;
    if (owner >= 0) begin
      eg = 3'b001 << owner;
      ec = bus.m_cyc[owner];
      es = bus.m_stb[owner];
      ew = bus.m_we[owner];
      ea = bus.s_ack ? eg : 3'b000;
    end
    eb = owner >= 0 || gap;
    exp_ack = ea;
    check("ctrl", {grant, busy, bus.m_ack, bus.s_cyc, bus.s_stb, bus.s_we}, {eg, eb, ea, ec, es, ew});
    check("rdata", bus.m_dat_o, bus.s_dat_i);
    if (owner >= 0)
      check("mux", {bus.s_adr, bus.s_sel, bus.s_cti, bus.s_dat_o},
            {bus.m_adr[owner*AW +: AW], bus.m_sel[owner*4 +: 4], bus.m_cti[owner*3 +: 3], bus.m_dat_i[owner*DW +: DW]});
    @(posedge sd_clk);
    if (rs) begin
      owner = -1; gap = 1'b0; pref = 1; age = '{0, 0, 0};
    end else begin
      nown = owner;
      ngap = 1'b0;
      if (owner >= 0) begin
        if (!bus.m_cyc[owner]) begin nown = -1; ngap = 1'b1; end
      end else if (!gap && r != 3'b000) begin
        nown = pick(r);
        if (nown != 0) pref = 3 - pref;
      end
      for (int i = 1; i < 3; i++) age[i] = (!r[i] || nown == i) ? 0 : age[i] + 1;
      owner = nown;
      gap = ngap;
    end
    #1;
  endtask

  task automatic new_beat(int i);
    bus.m_we[i] = 1'($urandom);
    bus.m_adr[i*AW +: AW] = AW'($urandom);
    bus.m_sel[i*4 +: 4] = 4'($urandom);
    bus.m_cti[i*3 +: 3] = 3'($urandom);
    bus.m_dat_i[i*DW +: DW] = $urandom;
  endtask

  task automatic drain();
    bus.m_cyc = 3'b000; bus.m_stb = 3'b000; bus.s_ack = 1'b0;
    for (int k = 0; k < 6 && (owner >= 0 || gap); k++) begin #4; step(); end
  endtask

  vec_t tbl[39];
  int t;
  logic c0;

  initial begin
    tbl = '{
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b100, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b100, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b100, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b000, 1'b1, 3'b100, 3'b100, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1},
      '{1'b0, 3'b010, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1},
      '{1'b0, 3'b100, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b010, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b1, 3'b010, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0},
      '{1'b0, 3'b110, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1},
      '{1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0}
    };
    reset = 1'b1;
    bus.m_cyc = 3'b000; bus.m_stb = 3'b000; bus.m_we = 3'b001;
    bus.m_adr = {24'h2a0002, 24'h150001, 24'h0c0000};
    bus.m_sel = 12'hf3c;
    bus.m_cti = 9'b000_000_000;
    bus.m_dat_i = {32'hcafe0002, 32'hbeef0001, 32'hface0000};
    bus.s_ack = 1'b0; bus.s_dat_i = 32'h0;
    @(posedge sd_clk); @(posedge sd_clk); #1;
    reset = 1'b0;

    foreach (tbl[k]) begin
      reset = tbl[k].rst;
      bus.m_cyc = tbl[k].rq; bus.m_stb = tbl[k].rq; bus.s_ack = tbl[k].ack;
      bus.s_dat_i = $urandom;
      #4;
      check("vec", {grant, bus.m_ack, bus.s_cyc, busy}, {tbl[k].g, tbl[k].mack, tbl[k].scyc, tbl[k].bsy});
      if (tbl[k].g == 3'b100) check("vec_adr", bus.s_adr, 24'h2a0002);
      step();
    end
    reset = 1'b0;

    bus.m_cyc = 3'b011; bus.m_stb = 3'b011; bus.s_ack = 1'b0; bus.m_cti[2:0] = 3'b010;
    #4; step();
    for (int b = 0; b < 8; b++) begin
      bus.m_cti[2:0] = (b == 7) ? 3'b111 : 3'b010;
      bus.s_ack = 1'b1;
      #4;
      check("burst_grant", grant, 3'b001);
      check("burst_ack", bus.m_ack, 3'b001);
      check("burst_cti", bus.s_cti, (b == 7) ? 3'b111 : 3'b010);
      step();
    end
    bus.m_cyc = 3'b010; bus.m_stb = 3'b010; bus.s_ack = 1'b0;
    #4; check("burst_drop", grant, 3'b001); step();
    #4; check("burst_gap", {grant, bus.s_cyc}, 4'b0000); step();
    #4; check("burst_idle", {grant, bus.s_cyc}, 4'b0000); step();
    #4; check("burst_next", grant, 3'b010); check("burst_m1_adr", bus.s_adr, 24'h150001); step();
    drain();

    bus.m_cyc = 3'b101; bus.m_stb = 3'b101; bus.s_ack = 1'b1;
    t = 0;
    while (grant !== 3'b100 && t < 200) begin
      #4;
      c0 = !(bus.m_cyc[0] && owner == 0);
      step();
      bus.m_cyc[0] = c0; bus.m_stb[0] = c0;
      t++;
    end
    check("starve_wait", t, 65);
    drain();

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!bus.m_cyc[i]) begin
          if ($urandom_range(0, 3) == 0) begin bus.m_cyc[i] = 1'b1; bus.m_stb[i] = 1'b1; new_beat(i); end
        end else if (exp_ack[i]) begin
          if ($urandom_range(0, 1) == 0) begin bus.m_cyc[i] = 1'b0; bus.m_stb[i] = 1'b0; end
          else begin bus.m_stb[i] = 1'b1; new_beat(i); end
        end else if (owner != i) begin
          if ($urandom_range(0, 19) == 0) begin bus.m_cyc[i] = 1'b0; bus.m_stb[i] = 1'b0; end
        end else if ($urandom_range(0, 7) == 0) bus.m_stb[i] = ~bus.m_stb[i];
      end
      bus.s_ack = ($urandom_range(0, 2) == 0);
      bus.s_dat_i = $urandom;
      #4; step();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
